// File: rtl/xor_response_checker.sv
// Checks a 2-input XOR DUT: applies each {a,b} vector, waits SETTLE_CYCLES,
// compares dut_out against a^b and tracks error, vector and coverage counts.
module xor_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             dut_out,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] vec_count,
    output logic [3:0]       cov_mask
);

    localparam int unsigned      CNT_W   = 4;
    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_nx;
    logic             cap_a, cap_b, cap_a_nx, cap_b_nx;
    logic [ERR_W-1:0] err_nx, vec_nx;
    logic [3:0]       cov_nx;
    logic             mismatch_nx;
    logic [1:0]       idx;
    logic             miss;

    // Next-state and next-value logic
    always_comb begin
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        cap_a_nx      = cap_a;
        cap_b_nx      = cap_b;
        err_nx        = err_count;
        vec_nx        = vec_count;
        cov_nx        = cov_mask;
        mismatch_nx   = 1'b0;
        idx           = {cap_a, cap_b};
        miss          = dut_out != (cap_a ^ cap_b);

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = ARMED;
                    err_nx   = '0;
                    vec_nx   = '0;
                    cov_nx   = '0;
                end
            end
            ARMED: begin
                if (valid) begin
                    cap_a_nx      = in_a;
                    cap_b_nx      = in_b;
                    settle_cnt_nx = CNT_W'(SETTLE_CYCLES);
                    state_nx      = SETTLE;
                end
            end
            SETTLE: begin
                // Counter was loaded with SETTLE_CYCLES, so leaving at 1 gives exactly that many cycles
                settle_cnt_nx = settle_cnt - CNT_W'(1);
                if (settle_cnt <= CNT_W'(1)) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                if (vec_count != CNT_MAX) begin
                    vec_nx = vec_count + ERR_W'(1);
                end
                cov_nx[idx] = 1'b1;
                if (miss) begin
                    mismatch_nx = 1'b1;
                    if (err_count != CNT_MAX) begin
                        err_nx = err_count + ERR_W'(1);
                    end
                end
                state_nx = (cov_nx == 4'b1111) ? DONE : ARMED;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs; reset wins over every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            cap_a      <= 1'b0;
            cap_b      <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            mismatch   <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
            cov_mask   <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_cnt_nx;
            cap_a      <= cap_a_nx;
            cap_b      <= cap_b_nx;
            ready      <= (state_nx == ARMED);
            busy       <= (state_nx == ARMED) || (state_nx == SETTLE) || (state_nx == SAMPLE);
            done       <= (state_nx == DONE);
            pass       <= (state_nx == DONE) && (err_nx == '0);
            mismatch   <= mismatch_nx;
            err_count  <= err_nx;
            vec_count  <= vec_nx;
            cov_mask   <= cov_nx;
        end
    end

endmodule

// File: tb/tb_xor_response_checker.sv
// Directed bench for xor_response_checker: table-driven sessions plus
// latency, reset-interrupt and saturation sequences.
module tb_xor_response_checker;

    localparam int unsigned S = 2;

    logic       clk, rst;
    logic       start, valid, in_a, in_b, dut_out;
    logic       ready, busy, done, pass, mismatch;
    logic [7:0] err_count, vec_count;
    logic [3:0] cov_mask;

    logic       s_start, s_valid, s_in_a, s_in_b, s_dut_out;
    logic       s_ready, s_busy, s_done, s_pass, s_mismatch;
    logic [1:0] s_err_count, s_vec_count;
    logic [3:0] s_cov_mask;

    int checks = 0;
    int errors = 0;
    int mm_pulses = 0;

    xor_response_checker #(.SETTLE_CYCLES(S), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .in_a(in_a), .in_b(in_b),
        .dut_out(dut_out), .ready(ready), .busy(busy), .done(done), .pass(pass),
        .mismatch(mismatch), .err_count(err_count), .vec_count(vec_count), .cov_mask(cov_mask)
    );

    xor_response_checker #(.SETTLE_CYCLES(S), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .valid(s_valid), .in_a(s_in_a), .in_b(s_in_b),
        .dut_out(s_dut_out), .ready(s_ready), .busy(s_busy), .done(s_done), .pass(s_pass),
        .mismatch(s_mismatch), .err_count(s_err_count), .vec_count(s_vec_count), .cov_mask(s_cov_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mismatch === 1'b1) mm_pulses++;

    typedef struct {
        logic       a, b, d, mm;
        int         err, vec;
        logic [3:0] cov;
        logic       dn, ps;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (ready !== 1'b1) chk({tag, "_ready_timeout"}, int'(ready), 1);
    endtask

    task automatic start_session(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_ready"}, int'(ready), 1);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_vec"}, int'(vec_count), 0);
        chk({tag, "_cov"}, int'(cov_mask), 0);
    endtask

    // Apply one vector; returns in the cycle where its result is visible
    task automatic send(input logic a, input logic b, input logic d, input string tag);
        wait_ready(tag);
        valid = 1'b1; in_a = a; in_b = b; dut_out = d;
        step();
        valid = 1'b0; in_a = ~a; in_b = ~b;
        repeat (S + 1) step();
    endtask

    initial begin
        rst = 1'b1; start = 0; valid = 0; in_a = 0; in_b = 0; dut_out = 0;
        s_start = 0; s_valid = 0; s_in_a = 0; s_in_b = 0; s_dut_out = 0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 4'b0001, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 2, 4'b0011, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 4'b0111, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 4, 4'b1111, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 4'b0001, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 2, 4'b0011, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 3, 4'b0111, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 4, 4'b1111, 1'b1, 1'b0};

        // Reset state
        step(); step();
        chk("rst_ready", int'(ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_vec", int'(vec_count), 0);
        chk("rst_cov", int'(cov_mask), 0);
        rst = 1'b0;
        step();
        chk("idle_busy", int'(busy), 0);

        // Saturation with ERR_W=2: five failing 11 vectors
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("sat_ready", int'(s_ready), 1);
            s_valid = 1'b1; s_in_a = 1'b1; s_in_b = 1'b1; s_dut_out = 1'b1;
            step();
            s_valid = 1'b0;
            repeat (S + 1) step();
            chk("sat_mismatch", int'(s_mismatch), 1);
            chk("sat_err", int'(s_err_count), (i + 1 > 3) ? 3 : i + 1);
            chk("sat_vec", int'(s_vec_count), (i + 1 > 3) ? 3 : i + 1);
        end
        chk("sat_cov", int'(s_cov_mask), 4'b1000);
        chk("sat_done", int'(s_done), 0);

        // Golden then stuck-at-0 sessions
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) start_session((i == 0) ? "start_gold" : "start_stuck");
            send(tbl[i].a, tbl[i].b, tbl[i].d, "tbl");
            chk($sformatf("tbl%0d_mismatch", i), int'(mismatch), int'(tbl[i].mm));
            chk($sformatf("tbl%0d_err", i), int'(err_count), tbl[i].err);
            chk($sformatf("tbl%0d_vec", i), int'(vec_count), tbl[i].vec);
            chk($sformatf("tbl%0d_cov", i), int'(cov_mask), int'(tbl[i].cov));
            chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].dn));
            chk($sformatf("tbl%0d_pass", i), int'(pass), int'(tbl[i].ps));
            chk($sformatf("tbl%0d_ready", i), int'(ready), int'(!tbl[i].dn));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(!tbl[i].dn));
            if (i == 3) chk("gold_pulses", mm_pulses, 0);
            if (i == 7) chk("stuck_pulses", mm_pulses, 2);
        end
        step();
        chk("done_level", int'(done), 1);

        // Latency: output only correct in the SAMPLE cycle; stray valid ignored
        start_session("start_lat");
        wait_ready("lat");
        valid = 1'b1; in_a = 1'b1; in_b = 1'b0; dut_out = 1'b0;
        step();
        in_a = 1'b0; in_b = 1'b1;
        chk("lat_c1_ready", int'(ready), 0);
        chk("lat_c1_busy", int'(busy), 1);
        step();
        valid = 1'b0;
        chk("lat_c2_mismatch", int'(mismatch), 0);
        step();
        dut_out = 1'b1;
        chk("lat_c3_ready", int'(ready), 0);
        step();
        chk("lat_c4_mismatch", int'(mismatch), 0);
        chk("lat_c4_ready", int'(ready), 1);
        chk("lat_c4_vec", int'(vec_count), 1);
        chk("lat_c4_err", int'(err_count), 0);
        chk("lat_c4_cov", int'(cov_mask), 4'b0100);

        // start in ARMED is ignored; repeated combination counted, coverage unchanged
        start = 1'b1;
        step();
        start = 1'b0;
        chk("armed_start_vec", int'(vec_count), 1);
        send(1'b1, 1'b0, 1'b1, "rep");
        chk("rep_vec", int'(vec_count), 2);
        chk("rep_cov", int'(cov_mask), 4'b0100);
        chk("rep_mismatch", int'(mismatch), 0);

        // Reset in the second SETTLE cycle with a wrong dut_out
        wait_ready("rs");
        valid = 1'b1; in_a = 1'b0; in_b = 1'b1; dut_out = 1'b0;
        step();
        valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rs_busy", int'(busy), 0);
        chk("rs_ready", int'(ready), 0);
        chk("rs_err", int'(err_count), 0);
        chk("rs_vec", int'(vec_count), 0);
        chk("rs_cov", int'(cov_mask), 0);
        chk("rs_mismatch", int'(mismatch), 0);
        rst = 1'b0;
        step();
        chk("rs_after_mismatch", int'(mismatch), 0);
        chk("rs_after_busy", int'(busy), 0);

        // Reset during SAMPLE, with start asserted alongside
        start_session("start_rs2");
        wait_ready("rs2");
        valid = 1'b1; in_a = 1'b0; in_b = 1'b1; dut_out = 1'b0;
        step();
        valid = 1'b0;
        step();
        step();
        rst = 1'b1; start = 1'b1;
        step();
        chk("rs2_mismatch", int'(mismatch), 0);
        chk("rs2_err", int'(err_count), 0);
        chk("rs2_busy", int'(busy), 0);
        rst = 1'b0; start = 1'b0;
        step();
        chk("rs2_after_mismatch", int'(mismatch), 0);
        chk("rs2_after_busy", int'(busy), 0);

        // Normal operation after reset
        start_session("start_post");
        send(1'b0, 1'b0, 1'b0, "post");
        chk("post_vec", int'(vec_count), 1);
        chk("post_err", int'(err_count), 0);
        chk("post_cov", int'(cov_mask), 4'b0001);
        chk("total_pulses", mm_pulses, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
